// File: rtl/linear_network_multicast_pipe_if.sv
// Handshake bundle for the multicast distribution pipe: one input stream,
// NUM_NODE output ports, each with its own valid/ready pair.
interface linear_network_multicast_pipe_if #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_NODE   = 4
);
    logic                           i_valid;
    logic [DATA_WIDTH-1:0]          i_data_bus;
    logic [NUM_NODE-1:0]            i_cmd;
    logic                           o_in_ready;
    logic [NUM_NODE-1:0]            o_valid;
    logic [DATA_WIDTH*NUM_NODE-1:0] o_data_bus;
    logic [NUM_NODE-1:0]            i_out_ready;

    modport master (
        output i_valid,
        output i_data_bus,
        output i_cmd,
        output i_out_ready,
        input  o_in_ready,
        input  o_valid,
        input  o_data_bus
    );

    modport slave (
        input  i_valid,
        input  i_data_bus,
        input  i_cmd,
        input  i_out_ready,
        output o_in_ready,
        output o_valid,
        output o_data_bus
    );
endinterface

// File: rtl/linear_network_multicast_pipe.sv
// Pipelined linear multicast network: one registered stage per node, each
// packet carries a destination mask and is dropped off at every marked node.
module linear_network_multicast_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_NODE   = 4
) (
    input logic clk,
    input logic rst_n,
    input logic i_en,
    linear_network_multicast_pipe_if.slave bus
);

    logic [NUM_NODE-1:0]   vld;
    logic [DATA_WIDTH-1:0] dat [NUM_NODE];
    logic [NUM_NODE-1:0]   msk [NUM_NODE];

    logic [NUM_NODE-1:0]   hit;
    logic [NUM_NODE-1:0]   dlv_ok;
    logic [NUM_NODE-1:0]   need_fwd;
    logic [NUM_NODE-1:0]   fwd_ok;
    logic [NUM_NODE-1:0]   adv;
    logic [NUM_NODE:0]     acc;
    logic [NUM_NODE-1:0]   ld;
    logic [NUM_NODE-1:0]   blk_clr;
    logic [NUM_NODE-1:0]   fwd_msk [NUM_NODE];
    logic [DATA_WIDTH-1:0] src_dat [NUM_NODE];
    logic [NUM_NODE-1:0]   src_msk [NUM_NODE];
    logic                  in_load;

    logic [NUM_NODE-1:0]            ovld;
    logic [DATA_WIDTH*NUM_NODE-1:0] odat;

    function automatic logic [NUM_NODE-1:0] above(input int k);
        logic [NUM_NODE-1:0] m;
        m = '0;
        for (int j = 0; j < NUM_NODE; j++) begin
            m[j] = (j > k);
        end
        return m;
    endfunction

    always_comb begin
        hit      = '0;
        dlv_ok   = '0;
        need_fwd = '0;
        for (int k = 0; k < NUM_NODE; k++) begin
            hit[k]      = msk[k][k];
            dlv_ok[k]   = !hit[k] | bus.i_out_ready[k];
            fwd_msk[k]  = msk[k] & above(k);
            need_fwd[k] = |fwd_msk[k];
        end
    end

    // Ready ripples from the tail back to the input; never depends on i_valid.
    always_comb begin
        acc           = '0;
        fwd_ok        = '0;
        adv           = '0;
        acc[NUM_NODE] = 1'b0;
        for (int k = NUM_NODE - 1; k >= 0; k--) begin
            fwd_ok[k] = !need_fwd[k] | acc[k+1];
            adv[k]    = i_en & vld[k] & dlv_ok[k] & fwd_ok[k];
            acc[k]    = i_en & (!vld[k] | adv[k]);
        end
    end

    always_comb begin
        in_load    = bus.i_valid & acc[0] & (|bus.i_cmd);
        ld         = '0;
        blk_clr    = '0;
        src_dat[0] = bus.i_data_bus;
        src_msk[0] = bus.i_cmd;
        ld[0]      = in_load;
        for (int k = 1; k < NUM_NODE; k++) begin
            src_dat[k] = dat[k-1];
            src_msk[k] = fwd_msk[k-1];
            ld[k]      = adv[k-1] & need_fwd[k-1];
        end
        // Delivered here but stuck behind a full neighbour: drop our own bit.
        for (int k = 0; k < NUM_NODE; k++) begin
            blk_clr[k] = i_en & vld[k] & hit[k]
                       & bus.i_out_ready[k] & !fwd_ok[k];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld <= '0;
            for (int k = 0; k < NUM_NODE; k++) begin
                dat[k] <= '0;
                msk[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_NODE; k++) begin
                if (acc[k]) begin
                    vld[k] <= ld[k];
                    if (ld[k]) begin
                        dat[k] <= src_dat[k];
                        msk[k] <= src_msk[k];
                    end
                end else if (blk_clr[k]) begin
                    msk[k][k] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        ovld = '0;
        odat = '0;
        for (int k = 0; k < NUM_NODE; k++) begin
            ovld[k] = i_en & vld[k] & hit[k];
            if (ovld[k]) begin
                odat[k*DATA_WIDTH +: DATA_WIDTH] = dat[k];
            end
        end
    end

    assign bus.o_valid    = ovld;
    assign bus.o_data_bus = odat;
    assign bus.o_in_ready = acc[0];

endmodule
